// File: rtl/alu_bit_serial_seq.sv
// -----------------------------------------------------------------------------
// alu_bit_serial_seq
//
// Bit-serial ALU sequencer. It latches two WIDTH-bit operands and an opcode,
// then drives the 1-bit slice ALUbitN once per clock, LSB first. The slice
// carry-out is fed back as the carry-in of the next bit. After the MSB it
// loads the assembled result and flags, and pulses done_o for one cycle.
//
// Ports
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low reset
//   start_i      request, accepted only while ready_o=1
//   abort_i      (ALU_SEQ_ABORT_EN only) drop the running operation
//   a_i, b_i     operands, sampled on accept
//   operacion_i  0000 AND, 0001 OR, 0010 ADD/SUB, 0011 SLT, 0100 XOR,
//                other codes are reserved and give 0
//   binvert_i    invert B and force carry-in=1 (SUB/SLT)
//   ready_o      high in IDLE
//   busy_o       high in RUN
//   done_o       one-cycle completion pulse
//   resultado_o  result, held from done until the next accept
//   c_o          carry out of the MSB
//   overflow_o   signed overflow for 0010/0011, 0 otherwise
//   zero_o       resultado_o == 0
//
// Optional build macro: ALU_SEQ_ABORT_EN adds the abort_i port.
// -----------------------------------------------------------------------------

module ALUbitN (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic       binvert_i,
  input  logic       less_i,
  input  logic [3:0] operacion_i,
  output logic       result_o,
  output logic       c_o,
  output logic       set_o
);
  logic b_eff;
  logic sum;

  assign b_eff = b_i ^ binvert_i;
  assign sum   = a_i ^ b_eff ^ c_i;
  assign c_o   = (a_i & b_eff) | (a_i & c_i) | (b_eff & c_i);
  // set_o is the raw adder output; the sequencer uses it at the MSB for SLT.
  assign set_o = sum;

  always_comb begin
    result_o = 1'b0;
    case (operacion_i)
      4'b0000: result_o = a_i & b_eff;
      4'b0001: result_o = a_i | b_eff;
      4'b0010: result_o = sum;
      4'b0011: result_o = less_i;
      4'b0100: result_o = a_i ^ b_eff;
      default: result_o = 1'b0;
    endcase
  end
endmodule

module alu_bit_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
`ifdef ALU_SEQ_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       operacion_i,
  input  logic             binvert_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] resultado_o,
  output logic             c_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operand and control registers captured on accept.
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             binv_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  // Partial result. It holds the WIDTH-1 bits already produced. The MSB comes
  // straight from the slice on the last step.
  logic [WIDTH-2:0] shift_q;

  // Held result and flags.
  logic [WIDTH-1:0] res_q;
  logic             c_q;
  logic             ovf_q;

  // FSM control strobes.
  logic accept;
  logic step;
  logic last_step;

  // Slice interface.
  logic slice_res;
  logic slice_c;
  logic slice_set;

  ALUbitN u_slice (
    .a_i         (a_q[cnt_q]),
    .b_i         (b_q[cnt_q]),
    .c_i         (carry_q),
    .binvert_i   (binv_q),
    .less_i      (1'b0),
    .operacion_i (op_q),
    .result_o    (slice_res),
    .c_o         (slice_c),
    .set_o       (slice_set)
  );

  // Final-step result formation.
  logic             is_arith;
  logic             is_slt;
  logic             ovf_now;
  logic [WIDTH-1:0] full_word;
  logic [WIDTH-1:0] final_res;

  assign is_arith  = (op_q == 4'b0010) || (op_q == 4'b0011);
  assign is_slt    = (op_q == 4'b0011);
  // On the last step carry_q is the carry into the MSB.
  assign ovf_now   = carry_q ^ slice_c;
  assign full_word = {slice_res, shift_q};
  // SLT compares signs: the true sign of A-B is the adder sign corrected by
  // overflow.
  assign final_res = is_slt ? {{(WIDTH-1){1'b0}}, slice_set ^ ovf_now}
                            : full_word;

  // ---- FSM state register ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM next state and strobes ----
  always_comb begin
    state_d   = state_q;
    ready_o   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
`ifdef ALU_SEQ_ABORT_EN
        if (abort_i) begin
          state_d = IDLE;
        end else
`endif
        begin
          step = 1'b1;
          if (cnt_q == LAST) begin
            last_step = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- Serial datapath: operand capture, bit stepping, result load ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      binv_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a_i;
      b_q     <= b_i;
      op_q    <= operacion_i;
      binv_q  <= binvert_i;
      carry_q <= binvert_i;
      cnt_q   <= '0;
    end else if (step) begin
      shift_q <= full_word[WIDTH-1:1];
      carry_q <= slice_c;
      cnt_q   <= cnt_q + CW'(1);
      if (last_step) begin
        res_q <= final_res;
        c_q   <= slice_c;
        ovf_q <= is_arith & ovf_now;
      end
    end
  end

  assign resultado_o = res_q;
  assign c_o         = c_q;
  assign overflow_o  = ovf_q;
  assign zero_o      = (res_q == '0);

endmodule
